// File: rtl/mem_pkg.sv
// Shared types and constants for the memory bus adapter.
// Optional bus timeout is enabled with `define MEM_TIMEOUT_EN (see mem_bus_adapter).
package mem_pkg;

    // Adapter sequencing states; 2'b11 is never entered.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    // Access size encoding carried on the op input.
    localparam logic [1:0] OP_BYTE    = 2'b00;
    localparam logic [1:0] OP_HALF    = 2'b01;
    localparam logic [1:0] OP_WORD    = 2'b10;
    localparam logic [1:0] OP_INVALID = 2'b11;

    // Byte-lane strobe patterns.
    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    // One-hot strobe for a single byte lane.
    function automatic logic [3:0] byte_strobe(input logic [1:0] lane);
        byte_strobe = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mem_read_align.sv
// Combinational read formatter: selects the addressed byte/half lane of a
// bus word and zero- or sign-extends it. Also used by store-buffer forwarding.
module mem_read_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension according to access size.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = rdata_i;
        case (op_i)
            OP_BYTE: data_o = {{24{~is_unsigned_i & byte_sel[7]}}, byte_sel};
            OP_HALF: data_o = {{16{~is_unsigned_i & half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_bus_adapter.sv
// 32-bit word-addressed bus master for the memory access unit.
// Handshake: bus_req rises with all bus_* fields valid and they stay stable
// until a cycle where bus_ack=1; bus_rdata/bus_err are only meaningful then.
// Optional feature: `define MEM_TIMEOUT_EN aborts a request after
// TIMEOUT_CYCLES REQ cycles without bus_ack (an ack in the expiry cycle wins).
module mem_bus_adapter
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        available,
    input  logic        is_write,
    input  logic        is_unsigned,
    input  logic [1:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        busy,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    output logic [1:0]  state_o
);

    mem_state_t  state_q;
    logic [31:0] out_q;
    logic        busy_q;
    logic        fault_q;
    logic        req_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic [1:0]  op_q;
    logic [1:0]  lane_q;
    logic        unsigned_q;

    logic        bad_req;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] aligned;

`ifdef MEM_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    logic [TIMEOUT_W-1:0] cnt_q;
`endif

    // Request decode: legality check plus lane strobes and replicated store data.
    always_comb begin
        bad_req = (op == OP_INVALID) ||
                  (op == OP_HALF && addr[0]) ||
                  (op == OP_WORD && addr[1:0] != 2'b00);
        wstrb_d = STRB_WORD;
        wdata_d = in;
        case (op)
            OP_BYTE: begin
                wstrb_d = byte_strobe(addr[1:0]);
                wdata_d = {4{in[7:0]}};
            end
            OP_HALF: begin
                wstrb_d = addr[1] ? STRB_HALF_HI : STRB_HALF_LO;
                wdata_d = {2{in[15:0]}};
            end
            default: begin
                wstrb_d = STRB_WORD;
                wdata_d = in;
            end
        endcase
    end

    mem_read_align u_align (
        .rdata_i      (bus_rdata),
        .op_i         (op_q),
        .addr_lo_i    (lane_q),
        .is_unsigned_i(unsigned_q),
        .data_o       (aligned)
    );

    // Sequencing FSM with registered bus and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            out_q      <= '0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wstrb_q    <= STRB_NONE;
            wdata_q    <= '0;
            op_q       <= OP_BYTE;
            lane_q     <= 2'b00;
            unsigned_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!available) begin
                        busy_q  <= 1'b0;
                        fault_q <= 1'b0;
                    end else if (bad_req) begin
                        fault_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        busy_q     <= 1'b1;
                        fault_q    <= 1'b0;
                        req_q      <= 1'b1;
                        we_q       <= is_write;
                        addr_q     <= addr[31:2];
                        wstrb_q    <= is_write ? wstrb_d : STRB_NONE;
                        wdata_q    <= wdata_d;
                        op_q       <= op;
                        lane_q     <= addr[1:0];
                        unsigned_q <= is_unsigned;
`ifdef MEM_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        fault_q <= bus_err;
                        if (!we_q && !bus_err) begin
                            out_q <= aligned;
                        end
                        state_q <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    if (!available) begin
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign fault     = fault_q;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q, 2'b00};
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Self-checking bench for mem_bus_adapter. Build with +define+MEM_TIMEOUT_EN
// to also exercise the bus timeout (DUT built with TIMEOUT_CYCLES=4).
module tb_mem_bus_adapter;

    localparam int TO_CYC = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        available, is_write, is_unsigned;
    logic [1:0]  op;
    logic [31:0] addr, req_in, dut_out;
    logic        busy, fault, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack, bus_err;
    logic [1:0]  state_o;

    int checks = 0;
    int errors = 0;

    // Architectural view of the load result register.
    logic [31:0] model_out;
    logic [31:0] exp_q[$];

    // Observations gathered by run_op.
    int          obs_req_cycles, obs_busy_cycles;
    logic        obs_req_seen, obs_busy_first, obs_fault_first, obs_stable, obs_hung;
    logic        obs_we, obs_fault, obs_busy_after, obs_fault_clear;
    logic [31:0] obs_addr, obs_wdata, obs_out;
    logic [3:0]  obs_wstrb;
    logic [1:0]  obs_state, obs_state_clear;

    mem_bus_adapter #(.TIMEOUT_CYCLES(TO_CYC), .TIMEOUT_W(8)) dut (
        .clk(clk), .reset(reset), .available(available), .is_write(is_write),
        .is_unsigned(is_unsigned), .op(op), .addr(addr), .in(req_in), .out(dut_out),
        .busy(busy), .fault(fault), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err), .state_o(state_o)
    );

    // Clock
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_bad(input logic [1:0] o, input logic [31:0] a);
        return (o == 2'd3) || (o == 2'd1 && a[0]) || (o == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [3:0] m_strb(input bit w, input logic [1:0] o, input logic [31:0] a);
        int unsigned lane;
        lane = a % 4;
        if (!w) return 4'd0;
        if (o == 2'd0) return 4'(1 << lane);
        if (o == 2'd1) return (lane >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] o, input logic [31:0] d);
        if (o == 2'd0) return (d % 256) * 32'h0101_0101;
        if (o == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] o, input logic [31:0] a,
                                           input bit u, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned lane;
        lane = a % 4;
        if (o == 2'd0) begin
            v = (rd >> (8 * lane)) % 256;
            if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (o == 2'd1) begin
            v = (rd >> (16 * (lane / 2))) % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // ---------------- driver ----------------
    // Presents one request, plays the slave with 'waits' non-ack REQ cycles,
    // then drops available and observes the return to IDLE.
    task automatic run_op(input bit w, input bit u, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int waits,
                          input bit err, input bit scramble);
        int cyc;
        @(posedge clk); #1;
        available = 1'b1; is_write = w; is_unsigned = u; op = o; addr = a; req_in = d;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
        obs_req_cycles = 0; obs_busy_cycles = 0; obs_stable = 1'b1;
        @(posedge clk); #1;
        obs_busy_first = busy; obs_fault_first = fault; obs_req_seen = bus_req;
        obs_addr = bus_addr; obs_wstrb = bus_wstrb; obs_wdata = bus_wdata; obs_we = bus_we;
        if (scramble) begin
            addr = $urandom; req_in = $urandom; op = 2'($urandom_range(0, 3));
            is_write = 1'($urandom); is_unsigned = 1'($urandom);
        end
        cyc = 0;
        while (bus_req && cyc < 100) begin
            obs_req_cycles++;
            if (busy) obs_busy_cycles++;
            if (bus_addr !== obs_addr || bus_wstrb !== obs_wstrb ||
                bus_wdata !== obs_wdata || bus_we !== obs_we) obs_stable = 1'b0;
            if (obs_req_cycles == waits + 1) begin
                bus_ack = 1'b1; bus_err = err; bus_rdata = rd;
            end else begin
                bus_ack = 1'b0; bus_err = 1'($urandom); bus_rdata = $urandom;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_err = 1'b0;
            cyc++;
        end
        obs_hung = (cyc >= 100);
        obs_fault = fault; obs_out = dut_out; obs_busy_after = busy; obs_state = state_o;
        available = 1'b0;
        @(posedge clk); #1;
        obs_fault_clear = fault; obs_state_clear = state_o;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++; if (dut_out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h want 0", dut_out); end
        checks++; if ({busy, fault, bus_req, bus_we} !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, fault, bus_req, bus_we}); end
        checks++; if (bus_addr !== 32'd0 || bus_wdata !== 32'd0 || bus_wstrb !== 4'd0) begin errors++; $display("FAIL reset_bus: addr %h wdata %h wstrb %h want 0", bus_addr, bus_wdata, bus_wstrb); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
        model_out = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_word_read();
        run_op(1'b0, 1'b0, 2'd2, 32'h100, $urandom, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        model_out = 32'hDEAD_BEEF;
        checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL word_rd_addr: got %h want 00000100", obs_addr); end
        checks++; if (obs_wstrb !== 4'd0 || obs_we !== 1'b0) begin errors++; $display("FAIL word_rd_strb: wstrb %b we %b want 0000 0", obs_wstrb, obs_we); end
        checks++; if (obs_out !== model_out) begin errors++; $display("FAIL word_rd_out: got %h want %h", obs_out, model_out); end
        checks++; if (obs_busy_first !== 1'b1 || obs_busy_cycles != 1 || obs_busy_after !== 1'b0) begin errors++; $display("FAIL word_rd_busy: first %b cycles %0d after %b want 1 1 0", obs_busy_first, obs_busy_cycles, obs_busy_after); end
        checks++; if (obs_fault !== 1'b0) begin errors++; $display("FAIL word_rd_fault: got %b want 0", obs_fault); end
    endtask

    task automatic test_byte_read();
        for (int u = 0; u < 2; u++) begin
            run_op(1'b0, 1'(u), 2'd0, 32'h103, $urandom, 32'h80FF_0000, 0, 1'b0, 1'b0);
            model_out = m_load(2'd0, 32'h103, 1'(u), 32'h80FF_0000);
            checks++; if (obs_out !== model_out) begin errors++; $display("FAIL byte_rd_u%0d: got %h want %h", u, obs_out, model_out); end
            checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL byte_rd_addr: got %h want 00000100", obs_addr); end
        end
    endtask

    task automatic test_half_write();
        run_op(1'b1, 1'b0, 2'd1, 32'h202, 32'h1234_ABCD, $urandom, 0, 1'b0, 1'b0);
        checks++; if (obs_addr !== 32'h200) begin errors++; $display("FAIL half_wr_addr: got %h want 00000200", obs_addr); end
        checks++; if (obs_wstrb !== m_strb(1'b1, 2'd1, 32'h202)) begin errors++; $display("FAIL half_wr_strb: got %b want 1100", obs_wstrb); end
        checks++; if (obs_wdata !== m_wdata(2'd1, 32'h1234_ABCD)) begin errors++; $display("FAIL half_wr_data: got %h want abcdabcd", obs_wdata); end
        checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL half_wr_we: got %b want 1", obs_we); end
        checks++; if (obs_out !== model_out) begin errors++; $display("FAIL half_wr_out: got %h want %h", obs_out, model_out); end
    endtask

    task automatic test_bad_requests();
        logic [1:0]  ops[3]   = '{2'd1, 2'd3, 2'd2};
        logic [31:0] addrs[3] = '{32'h201, 32'h0, 32'h102};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, 1'b0, ops[i], addrs[i], $urandom, $urandom, 0, 1'b0, 1'b0);
            checks++; if (obs_req_seen !== 1'b0 || obs_req_cycles != 0) begin errors++; $display("FAIL bad_req%0d: bus_req got %b want 0", i, obs_req_seen); end
            checks++; if (obs_fault_first !== 1'b1 || obs_busy_first !== 1'b0) begin errors++; $display("FAIL bad_fault%0d: fault %b busy %b want 1 0", i, obs_fault_first, obs_busy_first); end
            checks++; if (obs_fault_clear !== 1'b0 || obs_state_clear !== 2'd0) begin errors++; $display("FAIL bad_clear%0d: fault %b state %0d want 0 0", i, obs_fault_clear, obs_state_clear); end
            checks++; if (obs_out !== model_out) begin errors++; $display("FAIL bad_out%0d: got %h want %h", i, obs_out, model_out); end
        end
    endtask

    task automatic test_bus_err_wait();
        int exp_cycles;
        exp_cycles = (TO_EN && 5 >= TO_CYC) ? TO_CYC : 6;
        run_op(1'b0, 1'b0, 2'd2, 32'h340, $urandom, $urandom, 5, 1'b1, 1'b0);
        checks++; if (obs_req_cycles != exp_cycles || obs_hung) begin errors++; $display("FAIL err_req_cycles: got %0d want %0d", obs_req_cycles, exp_cycles); end
        checks++; if (obs_fault !== 1'b1) begin errors++; $display("FAIL err_fault: got %b want 1", obs_fault); end
        checks++; if (obs_out !== model_out) begin errors++; $display("FAIL err_out: got %h want %h", obs_out, model_out); end
        checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL err_stable: bus fields changed during REQ"); end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        available = 1'b1; is_write = 1'b0; op = 2'd2; addr = 32'h340; bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req: got %b want 1", bus_req); end
        reset = 1'b1;
        #1;
        checks++; if ({bus_req, busy, fault} !== 3'b000) begin errors++; $display("FAIL mid_reset: req/busy/fault got %b want 000", {bus_req, busy, fault}); end
        model_out = 32'd0;
        available = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        // A faulted request held in DONE must also lose fault on reset.
        available = 1'b1; op = 2'd3;
        @(posedge clk); #1;
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL mid_fault_set: got %b want 1", fault); end
        reset = 1'b1;
        #1;
        checks++; if (fault !== 1'b0 || dut_out !== model_out) begin errors++; $display("FAIL mid_fault_reset: fault %b out %h want 0 %h", fault, dut_out, model_out); end
        available = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        bit w, u, err, scr, bad, expire;
        logic [1:0]  o;
        logic [31:0] a, d, rd, want;
        int waits, exp_cycles;
        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom); u = 1'($urandom); o = 2'($urandom_range(0, 3));
            a = $urandom; d = $urandom; rd = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (o == 2'd2) ? 2'd0 : (o == 2'd1) ? {a[1], 1'b0} : a[1:0];
            waits = $urandom_range(0, 5); err = ($urandom_range(0, 5) == 0); scr = 1'($urandom);
            bad = m_bad(o, a);
            expire = TO_EN && (waits >= TO_CYC);
            exp_cycles = bad ? 0 : (expire ? TO_CYC : waits + 1);
            run_op(w, u, o, a, d, rd, waits, err, scr);
            if (!bad && !w && !err && !expire) model_out = m_load(o, a, u, rd);
            exp_q.push_back(model_out);
            checks++; if (obs_req_cycles != exp_cycles || obs_hung) begin errors++; $display("FAIL rnd%0d_cycles: got %0d want %0d", n, obs_req_cycles, exp_cycles); end
            checks++; if (obs_fault !== (bad || expire || err)) begin errors++; $display("FAIL rnd%0d_fault: got %b want %b", n, obs_fault, bad || expire || err); end
            if (!bad) begin
                checks++; if (obs_addr !== {a[31:2], 2'b00} || obs_wstrb !== m_strb(w, o, a) || obs_we !== w) begin errors++; $display("FAIL rnd%0d_bus: addr %h wstrb %b we %b want %h %b %b", n, obs_addr, obs_wstrb, obs_we, {a[31:2], 2'b00}, m_strb(w, o, a), w); end
                if (w) begin
                    checks++; if (obs_wdata !== m_wdata(o, d)) begin errors++; $display("FAIL rnd%0d_wdata: got %h want %h", n, obs_wdata, m_wdata(o, d)); end
                end
                checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_stable: bus fields changed during REQ", n); end
            end
            want = exp_q.pop_front();
            checks++; if (obs_out !== want) begin errors++; $display("FAIL rnd%0d_out: got %h want %h", n, obs_out, want); end
            checks++; if (obs_fault_clear !== 1'b0 || obs_state_clear !== 2'd0) begin errors++; $display("FAIL rnd%0d_clear: fault %b state %0d want 0 0", n, obs_fault_clear, obs_state_clear); end
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        run_op(1'b0, 1'b0, 2'd2, 32'h400, $urandom, $urandom, 1000, 1'b0, 1'b0);
        checks++; if (obs_req_cycles != TO_CYC || obs_hung) begin errors++; $display("FAIL to_cycles: got %0d want %0d", obs_req_cycles, TO_CYC); end
        checks++; if (obs_fault !== 1'b1 || obs_state !== 2'd2) begin errors++; $display("FAIL to_done: fault %b state %0d want 1 2", obs_fault, obs_state); end
        checks++; if (obs_out !== model_out) begin errors++; $display("FAIL to_out: got %h want %h", obs_out, model_out); end
        // Ack in the expiry cycle completes normally.
        run_op(1'b0, 1'b0, 2'd2, 32'h404, $urandom, 32'h1357_9BDF, TO_CYC - 1, 1'b0, 1'b0);
        model_out = 32'h1357_9BDF;
        checks++; if (obs_fault !== 1'b0 || obs_out !== model_out) begin errors++; $display("FAIL to_ack_wins: fault %b out %h want 0 %h", obs_fault, obs_out, model_out); end
    endtask
`endif

    initial begin
        reset = 1'b1; available = 1'b0; is_write = 1'b0; is_unsigned = 1'b0; op = 2'd0;
        addr = 32'd0; req_in = 32'd0; bus_rdata = 32'd0; bus_ack = 1'b0; bus_err = 1'b0;
        model_out = 32'd0;
        test_reset();
        test_word_read();
        test_byte_read();
        test_half_write();
        test_bad_requests();
        test_bus_err_wait();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
